// File: rtl/seq_detector_p_if.sv
// seq_detector_p_if: serial stream, pattern load, counter clear and match
// result signals for the pattern detector. The master side drives the
// stream and controls. The slave side is the detector itself.
interface seq_detector_p_if #(
  parameter int PAT_W   = 6,
  parameter int COUNT_W = 8
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic               din;
  logic               din_valid;
  logic               overlap;
  logic               pat_load;
  logic [PAT_W-1:0]   pat_in;
  logic               count_clr;
  logic               found;
  logic [FILL_W-1:0]  fill;
  logic [COUNT_W-1:0] match_count;

  modport master (
    output din, din_valid, overlap, pat_load, pat_in, count_clr,
    input  found, fill, match_count
  );

  modport slave (
    input  din, din_valid, overlap, pat_load, pat_in, count_clr,
    output found, fill, match_count
  );
endinterface

// File: rtl/seq_detector_p.sv
// seq_detector_p: parametrised serial pattern detector.
// The last PAT_W accepted bits are compared against a pattern register that
// can be loaded at run time. A match produces a registered one-cycle 'found'
// pulse. Detection can be overlapping or non-overlapping.
// Optional feature: define SEQDET_COUNT_EN to build the saturating match
// counter. When it is undefined, match_count is tied to zero and count_clr
// has no effect.
module seq_detector_p #(
  parameter int             PAT_W     = 6,
  parameter logic [PAT_W-1:0] RESET_PAT = 6'b101011,
  parameter int             COUNT_W   = 8
) (
  input logic            clk,
  input logic            reset_n,
  seq_detector_p_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill_q;
  logic              found_q;

  logic [PAT_W-1:0]  h_next;
  logic [FILL_W-1:0] f_next;
  logic              hit;

  // Candidate window and fill for the bit being offered this cycle. A hit only
  // counts when the bit is actually accepted, which excludes load cycles.
  always_comb begin
    h_next = {hist[PAT_W-2:0], bus.din};
    f_next = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
    hit    = bus.din_valid && !bus.pat_load && (f_next == FULL) && (h_next == pat_reg);
  end

  // Pattern, history, fill and pulse registers. Load wins over an accepted bit.
  // In non-overlapping mode a match empties the window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_reg <= RESET_PAT;
      hist    <= '0;
      fill_q  <= '0;
      found_q <= 1'b0;
    end else if (bus.pat_load) begin
      pat_reg <= bus.pat_in;
      hist    <= '0;
      fill_q  <= '0;
      found_q <= 1'b0;
    end else if (bus.din_valid) begin
      hist    <= h_next;
      found_q <= hit;
      fill_q  <= (hit && !bus.overlap) ? '0 : f_next;
    end else begin
      found_q <= 1'b0;
    end
  end

  assign bus.found = found_q;
  assign bus.fill  = fill_q;

`ifdef SEQDET_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // Saturating match counter. A clear wins over a coincident hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (bus.count_clr) begin
      count_q <= '0;
    end else if (hit && (count_q != '1)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.match_count = count_q;
`else
  logic unused_count_clr;

  assign unused_count_clr = bus.count_clr;
  assign bus.match_count  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_p.sv
// tb_seq_detector_p: directed, table-driven bench for seq_detector_p with
// hand-written sequences for counter saturation and clear/hit collision.
// Counter expectations follow SEQDET_COUNT_EN, so the bench suits either build.
module tb_seq_detector_p;
  localparam int PAT_W   = 6;
  localparam int COUNT_W = 8;

  typedef struct {
    logic       rst_n;
    logic       load;
    logic [5:0] pat;
    logic       valid;
    logic       din;
    logic       ovl;
    logic       clr;
    logic       e_found;
    logic [2:0] e_fill;
    int         e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  seq_detector_p_if #(.PAT_W(PAT_W), .COUNT_W(COUNT_W)) bus ();

  seq_detector_p #(
    .PAT_W    (PAT_W),
    .RESET_PAT(6'b101011),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Counter value the bench expects for a given number of matches.
  function automatic logic [7:0] exp_cnt(input int n);
`ifdef SEQDET_COUNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // Append one row to the vector table.
  task automatic add_vec(input logic rst_n, input logic load, input logic [5:0] pat,
                         input logic valid, input logic din, input logic ovl,
                         input logic clr, input logic e_found,
                         input logic [2:0] e_fill, input int e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.load = load; v.pat = pat; v.valid = valid; v.din = din;
    v.ovl = ovl; v.clr = clr; v.e_found = e_found; v.e_fill = e_fill; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then settle.
  task automatic apply_stimulus(input logic rst_n, input logic load, input logic [5:0] pat,
                                input logic valid, input logic din, input logic ovl,
                                input logic clr);
    @(negedge clk);
    reset_n       = rst_n;
    bus.pat_load  = load;
    bus.pat_in    = pat;
    bus.din_valid = valid;
    bus.din       = din;
    bus.overlap   = ovl;
    bus.count_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Compare the three outputs against expectations.
  task automatic check_output(input string name, input logic e_found,
                              input logic [2:0] e_fill, input int e_cnt);
    logic [7:0] want_cnt;
    want_cnt = exp_cnt(e_cnt);
    checks++;
    if (bus.found !== e_found) begin
      failures++;
      $display("[TB] FAIL %s found: got %0b want %0b", name, bus.found, e_found);
    end
    checks++;
    if (bus.fill !== e_fill) begin
      failures++;
      $display("[TB] FAIL %s fill: got %0d want %0d", name, bus.fill, e_fill);
    end
    checks++;
    if (bus.match_count !== want_cnt) begin
      failures++;
      $display("[TB] FAIL %s match_count: got %0d want %0d", name, bus.match_count, want_cnt);
    end
  endtask

  // Build the table, run it, then the saturation and clear/hit sequence.
  initial begin
    int hits;
    int cnt;
    reset_n = 1'b0; bus.pat_load = 1'b0; bus.pat_in = '0; bus.din_valid = 1'b0;
    bus.din = 1'b0; bus.overlap = 1'b1; bus.count_clr = 1'b0;

    // rst_n load pat valid din ovl clr | found fill cnt
    add_vec(0, 0, 6'h00, 0, 0, 1, 0, 0, 0, 0);
    // default pattern 101011, overlapping
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 1, 0);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 2, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 3, 0);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 4, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 5, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 1, 6, 1);
    add_vec(1, 0, 6'h00, 0, 0, 1, 0, 0, 6, 1);
    // reload, then 1,0,1 / three idle cycles / 0,1,1
    add_vec(1, 1, 6'b101011, 0, 0, 1, 0, 0, 0, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 1, 1);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 2, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 3, 1);
    add_vec(1, 0, 6'h00, 0, 1, 1, 0, 0, 3, 1);
    add_vec(1, 0, 6'h00, 0, 0, 1, 0, 0, 3, 1);
    add_vec(1, 0, 6'h00, 0, 1, 1, 0, 0, 3, 1);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 4, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 5, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 1, 6, 2);
    // mid-stream bits, then load together with a valid bit (bit dropped)
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 2);
    add_vec(1, 1, 6'b101011, 1, 1, 1, 0, 0, 0, 2);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 1, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 2, 2);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 3, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 4, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 5, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 2);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 1, 6, 3);
    // all-ones pattern, overlapping: pulses on bits 6, 7, 8
    add_vec(1, 1, 6'b111111, 0, 0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 8; i++)
      add_vec(1, 0, 6'h00, 1, 1, 1, 0, (i >= 5), (i >= 5) ? 3'd6 : 3'(i + 1), 3 + ((i >= 5) ? i - 4 : 0));
    // all-ones pattern, non-overlapping: one pulse, fill restarts
    add_vec(1, 1, 6'b111111, 0, 0, 0, 0, 0, 0, 6);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 1, 6);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 2, 6);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 3, 6);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 4, 6);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 5, 6);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 1, 0, 7);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 1, 7);
    add_vec(1, 0, 6'h00, 1, 1, 0, 0, 0, 2, 7);
    add_vec(1, 0, 6'h00, 0, 0, 0, 1, 0, 2, 0);
    // four matching bits then reset: pattern must return to 101011
    add_vec(1, 1, 6'b111111, 0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 1, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 2, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 3, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 4, 0);
    add_vec(0, 1, 6'b111111, 1, 1, 1, 0, 0, 0, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 1, 0);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 2, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 3, 0);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 4, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 5, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 1, 6, 1);
    // overlapping re-match with a coincident clear, then a plain re-match
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 1);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 1);
    add_vec(1, 0, 6'h00, 1, 1, 1, 1, 1, 6, 0);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 0);
    add_vec(1, 0, 6'h00, 1, 0, 1, 0, 0, 6, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 0, 6, 0);
    add_vec(1, 0, 6'h00, 1, 1, 1, 0, 1, 6, 1);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].load, vecs[i].pat, vecs[i].valid,
                     vecs[i].din, vecs[i].ovl, vecs[i].clr);
      check_output($sformatf("vec%0d", i), vecs[i].e_found, vecs[i].e_fill, vecs[i].e_cnt);
    end

    // Saturation: load keeps the count, then a long run of all-ones matches.
    apply_stimulus(1, 1, 6'b111111, 0, 0, 1, 0);
    check_output("sat_load", 1'b0, 3'd0, 1);
    for (int i = 0; i < 270; i++) begin
      hits = (i >= 5) ? i - 4 : 0;
      cnt  = (1 + hits > 255) ? 255 : 1 + hits;
      apply_stimulus(1, 0, 6'h00, 1, 1, 1, 0);
      check_output($sformatf("sat%0d", i), (i >= 5), (i >= 5) ? 3'd6 : 3'(i + 1), cnt);
    end

    // Clear colliding with a hit on a saturated counter.
    apply_stimulus(1, 0, 6'h00, 1, 1, 1, 1);
    check_output("clr_hit", 1'b1, 3'd6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
